// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
// Holds the FSM state encoding, the data width and the baud divisor helper.
package fifo_uart_tx_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        LOAD  = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd5
    } state_e;

    // Integer division; the remainder is deliberately dropped.
    function automatic int calc_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/fifo_uart_tx_baud_tick.sv
// Bit-period counter: counts 0..DIV-1, wraps, and flags the last cycle.
// A synchronous clear restarts the period so every bit is exactly DIV cycles.
module uart_baud_tick #(
    parameter int DIV = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic tick_o
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == CW'(DIV - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr_i || tick_o)
            cnt_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// 8N1 UART transmitter that pulls bytes from an upstream FIFO.
// One byte per frame: READ strobes the FIFO, LOAD captures its data, then start/data/stop.
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD      = 115_200,
    parameter int STOP_BITS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_ren,
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);
    localparam int DIV = calc_div(CLK_FREQ, BAUD);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic              tx_q, tx_d;
    logic              ren_q, ren_d;
    logic              done_c;
    logic              tick, baud_clr;

    // Hold the period counter at zero while idle and restart it on every state change.
    assign baud_clr = (state_d != state_q) || (state_q == IDLE);

    uart_baud_tick #(.DIV(DIV)) u_baud (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (baud_clr),
        .tick_o (tick)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        ren_d     = 1'b0;
        done_c    = 1'b0;
        case (state_q)
            IDLE: begin
                if (en && !fifo_empty) begin
                    state_d = READ;
                    ren_d   = 1'b1;
                end
            end
            READ: state_d = LOAD;
            LOAD: begin
                shreg_d   = fifo_data;
                bit_cnt_d = '0;
                tx_d      = 1'b0;
                state_d   = START;
            end
            START: begin
                if (tick) begin
                    tx_d    = shreg_q[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d = '0;
                        tx_d      = 1'b1;
                        state_d   = STOP;
                    end else begin
                        shreg_d   = shreg_q >> 1;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        tx_d      = shreg_q[1];
                    end
                end
            end
            STOP: begin
                // bit_cnt is reused here to count stop bits.
                if (tick) begin
                    if (bit_cnt_q == 3'(STOP_BITS - 1)) begin
                        done_c  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
            ren_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            ren_q     <= ren_d;
        end
    end

    assign fifo_ren   = ren_q;
    assign tx         = tx_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = done_c;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx at DIV=10: one DUT with 1 stop bit, one with 2.
// A small array-based FIFO model feeds each DUT; frames are checked bit slot by bit slot.
module tb_fifo_uart_tx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       en1 = 1'b0, en2 = 1'b0;
    logic       empty1, empty2;
    logic [7:0] data1 = 8'h00, data2 = 8'h00;
    logic       ren1, ren2, tx1, tx2, busy1, busy2, fd1, fd2;

    logic [7:0] mem1 [0:15];
    logic [7:0] mem2 [0:15];
    int wp1 = 0, rp1 = 0, wp2 = 0, rp2 = 0;

    assign empty1 = (wp1 == rp1);
    assign empty2 = (wp2 == rp2);

    always @(posedge clk) begin
        if (ren1) begin
            data1 <= mem1[rp1 % 16];
            rp1   <= rp1 + 1;
        end
        if (ren2) begin
            data2 <= mem2[rp2 % 16];
            rp2   <= rp2 + 1;
        end
    end

    fifo_uart_tx #(.CLK_FREQ(1_000_000), .BAUD(100_000), .STOP_BITS(1)) dut1 (
        .clk(clk), .rst(rst), .en(en1), .fifo_empty(empty1), .fifo_data(data1),
        .fifo_ren(ren1), .tx(tx1), .busy(busy1), .frame_done(fd1)
    );

    fifo_uart_tx #(.CLK_FREQ(1_000_000), .BAUD(100_000), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .en(en2), .fifo_empty(empty2), .fifo_data(data2),
        .fifo_ren(ren2), .tx(tx2), .busy(busy2), .frame_done(fd2)
    );

    logic sel = 1'b0;
    logic ren_s, tx_s, busy_s, fd_s;
    assign ren_s  = sel ? ren2  : ren1;
    assign tx_s   = sel ? tx2   : tx1;
    assign busy_s = sel ? busy2 : busy1;
    assign fd_s   = sel ? fd2   : fd1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit s, input logic [7:0] b);
        if (!s) begin
            mem1[wp1 % 16] = b;
            wp1++;
        end else begin
            mem2[wp2 % 16] = b;
            wp2++;
        end
    endtask

    // Waits for the read strobe, then walks the whole frame cycle by cycle.
    // Cycle 0 is the READ cycle; slot s covers cycles 2+10s .. 11+10s.
    task automatic frame(input logic [7:0] b, input int sb, input int drop_c, output int waited);
        int   last, fd_cnt, fd_at, ren_x, busy_lo, s, p;
        logic first;
        bit   stable;
        logic [31:0] exp;
        fd_cnt = 0; fd_at = -1; ren_x = 0; busy_lo = 0; first = 1'b0; stable = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!ren_s && waited < 2000) begin
            waited++;
            @(negedge clk);
        end
        if (!ren_s) begin
            chk("ren_timeout", 32'd0, 32'd1);
            return;
        end
        last = 1 + (9 + sb) * 10;
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            if (c == drop_c) en1 = 1'b0;
            if (fd_s) begin
                fd_cnt++;
                fd_at = c;
            end
            if (ren_s) ren_x++;
            if (!busy_s) busy_lo++;
            if (c == 1) begin
                chk("load_tx_high", 32'(tx_s), 32'd1);
            end else begin
                s = (c - 2) / 10;
                p = (c - 2) % 10;
                if (p == 0) begin
                    first  = tx_s;
                    stable = 1'b1;
                end else if (tx_s !== first) begin
                    stable = 1'b0;
                end
                if (p == 9) begin
                    if (s == 0)      exp = 32'd0;
                    else if (s <= 8) exp = 32'(b[s-1]);
                    else             exp = 32'd1;
                    chk($sformatf("byte%02h_slot%0d", b, s), stable ? 32'(first) : 32'd2, exp);
                end
            end
        end
        chk("frame_done_count", 32'(fd_cnt), 32'd1);
        chk("frame_done_cycle", 32'(fd_at), 32'(last));
        chk("ren_extra_in_frame", 32'(ren_x), 32'd0);
        chk("busy_low_in_frame", 32'(busy_lo), 32'd0);
        @(negedge clk);
        chk("idle_busy", 32'(busy_s), 32'd0);
        chk("idle_tx", 32'(tx_s), 32'd1);
    endtask

    int w, cnt_ren, cnt_txlo, cnt_busy;

    initial begin
        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_tx", 32'(tx1), 32'd1);
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_ren", 32'(ren1), 32'd0);
        chk("rst_fd", 32'(fd1), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: single byte 0xAA
        push(1'b0, 8'hAA);
        en1 = 1'b1;
        frame(8'hAA, 1, 0, w);
        chk("t1_ren_latency", 32'(w), 32'd0);

        // 2: back-to-back 0x00, 0xFF, 0x5A with 3 idle-high cycles between frames
        push(1'b0, 8'h00);
        push(1'b0, 8'hFF);
        push(1'b0, 8'h5A);
        frame(8'h00, 1, 0, w);
        frame(8'hFF, 1, 0, w);
        chk("t2_gap_ff", 32'(w), 32'd0);
        frame(8'h5A, 1, 0, w);
        chk("t2_gap_5a", 32'(w), 32'd0);
        chk("t2_ren_total", 32'(rp1), 32'd4);

        // 3: empty FIFO, en=1 for 500 cycles
        cnt_ren = 0; cnt_txlo = 0; cnt_busy = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (ren1) cnt_ren++;
            if (!tx1) cnt_txlo++;
            if (busy1) cnt_busy++;
        end
        chk("t3_ren", 32'(cnt_ren), 32'd0);
        chk("t3_tx_low", 32'(cnt_txlo), 32'd0);
        chk("t3_busy", 32'(cnt_busy), 32'd0);

        // 4: en dropped during data bit 3 of 0x81; 0x42 waits for en
        push(1'b0, 8'h81);
        push(1'b0, 8'h42);
        frame(8'h81, 1, 47, w);
        cnt_ren = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ren1) cnt_ren++;
        end
        chk("t4_no_read_en0", 32'(cnt_ren), 32'd0);
        en1 = 1'b1;
        frame(8'h42, 1, 0, w);
        chk("t4_resume_latency", 32'(w), 32'd0);

        // 5: reset during data bit 4 of 0x3C, then 0x99 goes out cleanly
        push(1'b0, 8'h3C);
        push(1'b0, 8'h99);
        w = 0;
        @(negedge clk);
        while (!ren1 && w < 2000) begin
            w++;
            @(negedge clk);
        end
        chk("t5_ren_seen", 32'(ren1), 32'd1);
        for (int c = 1; c <= 57; c++) @(negedge clk);
        chk("t5_pre_rst_bit4", 32'(tx1), 32'd1);
        chk("t5_pre_rst_busy", 32'(busy1), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("t5_rst_tx", 32'(tx1), 32'd1);
        chk("t5_rst_busy", 32'(busy1), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        frame(8'h99, 1, 0, w);
        chk("t5_after_rst_latency", 32'(w), 32'd0);
        chk("t5_reads", 32'(rp1), 32'd8);

        // 6: two stop bits, byte 0xC3
        sel = 1'b1;
        push(1'b1, 8'hC3);
        en2 = 1'b1;
        frame(8'hC3, 2, 0, w);
        chk("t6_ren_latency", 32'(w), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
